// File: rtl/class_score_collector_pkg.sv
// Shared definitions for the class score collector.
//   SCORE_W     : width of one signed class score
//   NUM_CLASSES : slots per frame (beat k of a frame is class k)
//   IDX_W       : width of the slot write index
//   SCORE_MIN   : most negative score, used to pad short frames
//   state_e     : collector FSM state encoding
package class_score_collector_pkg;

  localparam int unsigned SCORE_W     = 16;
  localparam int unsigned NUM_CLASSES = 10;
  localparam int unsigned IDX_W       = 4;

  // Padding value for missing classes; it can never win an argmax.
  localparam logic [SCORE_W-1:0] SCORE_MIN = {1'b1, {(SCORE_W-1){1'b0}}};

  typedef enum logic [1:0] {
    StFill = 2'd0,
    StDrop = 2'd1,
    StHold = 2'd2
  } state_e;

endpackage

// File: rtl/class_score_collector.sv
// Collects ten serial class scores (one per valid/ready beat, class order 0..9)
// into slot registers and presents them as one stable parallel frame.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   in_valid        : in_score/in_last valid
//   in_ready        : beat accepted this cycle when in_valid is also high
//   in_score        : score of the current class
//   in_last         : final beat of the frame
//   out_valid       : image_numbers holds a complete frame
//   out_ready       : downstream consumes the frame
//   image_numbers   : slot k at [k*SCORE_W +: SCORE_W]
//   short_frame     : frame had fewer than NUM_CLASSES beats (padded with SCORE_MIN)
//   overflow        : frame had more than NUM_CLASSES beats (extra beats dropped)
module class_score_collector
  import class_score_collector_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [SCORE_W-1:0]             in_score,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_CLASSES*SCORE_W-1:0] image_numbers,
  output logic                           short_frame,
  output logic                           overflow
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_CLASSES - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
  logic [SCORE_W-1:0] slots_q [NUM_CLASSES];
  logic [SCORE_W-1:0] slots_d [NUM_CLASSES];
  logic               short_q, short_d;
  logic               overflow_q, overflow_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               accept;

  always_comb begin
    state_d    = state_q;
    wr_idx_d   = wr_idx_q;
    slots_d    = slots_q;
    short_d    = short_q;
    overflow_d = overflow_q;
    accept     = in_valid & in_ready_q;

    unique case (state_q)
      StFill: begin
        if (accept) begin
          slots_d[wr_idx_q] = in_score;
          wr_idx_d          = wr_idx_q + IDX_W'(1);
          if (wr_idx_q == LastIdx) begin
            if (in_last) begin
              state_d = StHold;
            end else begin
              state_d    = StDrop;
              overflow_d = 1'b1;
            end
          end else if (in_last) begin
            // Early end of frame: pad the remaining classes in the same cycle.
            for (int k = 0; k < NUM_CLASSES; k++) begin
              if (k > int'(wr_idx_q)) slots_d[k] = SCORE_MIN;
            end
            short_d = 1'b1;
            state_d = StHold;
          end
        end
      end
      StDrop: begin
        if (accept && in_last) state_d = StHold;
      end
      StHold: begin
        if (out_ready) begin
          state_d    = StFill;
          wr_idx_d   = '0;
          short_d    = 1'b0;
          overflow_d = 1'b0;
        end
      end
      default: state_d = StFill;
    endcase

    // Handshake outputs are registered copies of the next-state decode.
    in_ready_d  = (state_d != StHold);
    out_valid_d = (state_d == StHold);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StFill;
      wr_idx_q    <= '0;
      short_q     <= 1'b0;
      overflow_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      for (int k = 0; k < NUM_CLASSES; k++) slots_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      short_q     <= short_d;
      overflow_q  <= overflow_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      for (int k = 0; k < NUM_CLASSES; k++) slots_q[k] <= slots_d[k];
    end
  end

  always_comb begin
    image_numbers = '0;
    for (int k = 0; k < NUM_CLASSES; k++) begin
      image_numbers[k*SCORE_W +: SCORE_W] = slots_q[k];
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign short_frame = short_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_class_score_collector.sv
module tb_class_score_collector;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [15:0]  in_score;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [159:0] image_numbers;
  logic         short_frame;
  logic         overflow;

  int checks   = 0;
  int failures = 0;

  logic [15:0]  sc [20];
  logic [159:0] exp_img;
  logic [159:0] snap;
  logic [15:0]  seq [20];
  logic [159:0] exp_a, exp_b;

  class_score_collector dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_score      (in_score),
    .in_last       (in_last),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .image_numbers (image_numbers),
    .short_frame   (short_frame),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Index of the first maximum signed slot, as Max_selector would pick it.
  function automatic int argmax(input logic [159:0] img);
    int best = 0;
    for (int k = 1; k < 10; k++) begin
      if ($signed(img[k*16 +: 16]) > $signed(img[best*16 +: 16])) best = k;
    end
    return best;
  endfunction

  // Present one beat and wait (bounded) until it is accepted.
  task automatic beat(input logic [15:0] s, input logic l);
    int n = 0;
    in_valid = 1'b1;
    in_score = s;
    in_last  = l;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("beat_accept_timeout", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Send sc[0..n-1] with in_last on the final beat.
  task automatic send_n(input int n);
    for (int i = 0; i < n; i++) beat(sc[i], (i == n - 1));
  endtask

  initial begin
    int idx, lows, frames, cyc;
    logic rdy;
    rst = 1'b1; in_valid = 1'b0; in_score = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_image", image_numbers, '0);
    check("rst_short", short_frame, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: scores 1..10, out_ready high.
    for (int i = 0; i < 10; i++) sc[i] = 16'(i + 1);
    exp_img = {16'd10, 16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
    send_n(10);
    check("t1_out_valid", out_valid, 1'b1);
    check("t1_in_ready", in_ready, 1'b0);
    check("t1_image", image_numbers, exp_img);
    check("t1_slot9", image_numbers[159:144], 16'd10);
    check("t1_short", short_frame, 1'b0);
    check("t1_overflow", overflow, 1'b0);
    check("t1_argmax", argmax(image_numbers), 9);
    @(posedge clk);
    #1;
    check("t1_released", out_valid, 1'b0);
    check("t1_back_fill", in_ready, 1'b1);

    // 2: downstream stalls for 6 cycles; upstream keeps offering a beat.
    out_ready = 1'b0;
    sc[0] = 1; sc[1] = 2; sc[2] = 3; sc[3] = 4; sc[4] = 5;
    sc[5] = 14; sc[6] = 7; sc[7] = 8; sc[8] = 9; sc[9] = 10;
    exp_img = {16'd10, 16'd9, 16'd8, 16'd7, 16'd14, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
    send_n(10);
    snap = image_numbers;
    check("t2_image", snap, exp_img);
    in_valid = 1'b1; in_score = 16'hdead; in_last = 1'b0;
    for (int c = 0; c < 6; c++) begin
      check("t2_hold_in_ready", in_ready, 1'b0);
      check("t2_hold_out_valid", out_valid, 1'b1);
      check("t2_hold_stable", image_numbers, exp_img);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t2_released", out_valid, 1'b0);
    check("t2_back_fill", in_ready, 1'b1);
    check("t2_slots_kept", image_numbers, exp_img);

    // 3: short frame of three beats.
    sc[0] = 0; sc[1] = 13; sc[2] = 3;
    exp_img = {{7{16'h8000}}, 16'd3, 16'd13, 16'd0};
    send_n(3);
    check("t3_out_valid", out_valid, 1'b1);
    check("t3_image", image_numbers, exp_img);
    check("t3_slot1", image_numbers[31:16], 16'd13);
    check("t3_short", short_frame, 1'b1);
    check("t3_overflow", overflow, 1'b0);
    @(posedge clk);
    #1;
    check("t3_short_clear", short_frame, 1'b0);

    // 4: twelve beats, extras dropped.
    for (int i = 0; i < 12; i++) sc[i] = 16'(100 + i);
    exp_img = {16'd109, 16'd108, 16'd107, 16'd106, 16'd105,
               16'd104, 16'd103, 16'd102, 16'd101, 16'd100};
    for (int i = 0; i < 10; i++) beat(sc[i], 1'b0);
    check("t4_overflow_early", overflow, 1'b1);
    check("t4_no_valid_in_drop", out_valid, 1'b0);
    beat(sc[10], 1'b0);
    check("t4_drop_in_ready", in_ready, 1'b1);
    beat(sc[11], 1'b1);
    check("t4_out_valid", out_valid, 1'b1);
    check("t4_image", image_numbers, exp_img);
    check("t4_overflow", overflow, 1'b1);
    check("t4_short", short_frame, 1'b0);
    @(posedge clk);
    #1;
    check("t4_overflow_clear", overflow, 1'b0);

    // 5: reset mid-frame.
    for (int i = 0; i < 4; i++) beat(16'h0777, 1'b0);
    rst = 1'b1;
    #1;
    check("t5_rst_image", image_numbers, '0);
    check("t5_rst_out_valid", out_valid, 1'b0);
    check("t5_rst_short", short_frame, 1'b0);
    check("t5_rst_overflow", overflow, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) sc[i] = 16'(20 + i);
    exp_img = {16'd29, 16'd28, 16'd27, 16'd26, 16'd25,
               16'd24, 16'd23, 16'd22, 16'd21, 16'd20};
    send_n(10);
    check("t5_out_valid", out_valid, 1'b1);
    check("t5_image", image_numbers, exp_img);
    @(posedge clk);
    #1;

    // 6: back-to-back frames, in_valid held high.
    for (int i = 0; i < 10; i++) begin
      seq[i]      = 16'(50 + i);
      seq[10 + i] = 16'(16'hfff0 - 16'(i));
    end
    exp_a = {16'd59, 16'd58, 16'd57, 16'd56, 16'd55,
             16'd54, 16'd53, 16'd52, 16'd51, 16'd50};
    exp_b = {16'hffe7, 16'hffe8, 16'hffe9, 16'hffea, 16'hffeb,
             16'hffec, 16'hffed, 16'hffee, 16'hffef, 16'hfff0};
    idx = 0; lows = 0; frames = 0; cyc = 0;
    while (frames < 2 && cyc < 60) begin
      if (idx < 20) begin
        in_valid = 1'b1;
        in_score = seq[idx];
        in_last  = ((idx % 10) == 9);
      end else begin
        in_valid = 1'b0;
      end
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy && idx < 20) idx++;
      else if (!rdy) lows++;
      if (out_valid) begin
        check("t6_frame", image_numbers, (frames == 0) ? exp_a : exp_b);
        frames++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("t6_frames_seen", frames, 2);
    check("t6_beats_used", idx, 20);
    check("t6_idle_cycles", lows, 1);
    @(posedge clk);
    #1;
    check("t6_released", out_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
